// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and constants for the UART transmitter
package uart_tx_pkg;

    localparam int UART_BYTE_W          = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte write port and serial/status outputs of the UART transmitter
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic [UART_BYTE_W-1:0] uart;
    logic                   uart_we;
    logic                   tx;
    logic                   busy;
    logic                   fifo_full;
    logic                   overflow;

    modport master (
        output uart, uart_we,
        input  tx, busy, fifo_full, overflow
    );

    modport slave (
        input  uart, uart_we,
        output tx, busy, fifo_full, overflow
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - circular byte buffer feeding the UART transmitter
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [UART_BYTE_W-1:0]        din,
    output logic [UART_BYTE_W-1:0]        dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [UART_BYTE_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   do_push;
    logic                   do_pop;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A full buffer still accepts a write when the same cycle frees a slot.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered 8N1 UART transmitter with overflow reporting
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);
    localparam int            BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_e            state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [UART_BYTE_W-1:0] shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   overflow_q, overflow_d;

    logic                   fifo_pop;
    logic [UART_BYTE_W-1:0] fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                   bit_end;

    uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.uart_we),
        .pop   (fifo_pop),
        .din   (bus.uart),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = bit_end ? '0 : baud_q + BW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    bit_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Chain straight into the next start bit so queued bytes leave no idle gap.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        bit_d    = '0;
                        state_d  = START;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase

        busy_d     = (state_q != IDLE) || (fifo_count != '0);
        overflow_d = bus.uart_we && fifo_full && !fifo_pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.tx        = tx_q;
    assign bus.busy      = busy_q;
    assign bus.fifo_full = fifo_full;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx (4 clocks per bit, 4-entry FIFO)
module tb_uart_tx;

    localparam int LOGN = 4096;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    logic tx_log   [LOGN];
    logic busy_log [LOGN];
    logic full_log [LOGN];
    logic ov_log   [LOGN];

    uart_tx_if bus ();

    uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Entry k holds the outputs as seen after rising edge number k.
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            tx_log[cyc]   = bus.tx;
            busy_log[cyc] = bus.busy;
            full_log[cyc] = bus.fifo_full;
            ov_log[cyc]   = bus.overflow;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, required end before 200000", $time);
        $fatal(1);
    end

    function automatic logic [39:0] exp_frame(input logic [7:0] b);
        logic [39:0] v;
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       v[i] = 1'b0;
            else if (i < 36) v[i] = b[(i - 4) / 4];
            else             v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [39:0] got_frame(input int s);
        logic [39:0] v;
        for (int i = 0; i < 40; i++) v[i] = tx_log[s + i];
        return v;
    endfunction

    task automatic wait_until(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic push_at(input int edge_n, input logic [7:0] b);
        while (cyc < edge_n - 1) @(negedge clk);
        bus.uart    = b;
        bus.uart_we = 1'b1;
        @(negedge clk);
        bus.uart_we = 1'b0;
    endtask

    task automatic test_reset();
        logic ok;
        int   base;
        bus.uart    = 8'h99;
        bus.uart_we = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.tx !== 1'b1) $display("FAIL reset_tx got %b want 1", bus.tx); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
        total++; if (bus.fifo_full !== 1'b0) $display("FAIL reset_full got %b want 0", bus.fifo_full); else passed++;
        total++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", bus.overflow); else passed++;
        rst         = 1'b1;
        bus.uart_we = 1'b0;
        base = cyc;
        wait_until(base + 22);
        ok = 1'b1;
        for (int k = base + 1; k <= base + 20; k++)
            if (busy_log[k] !== 1'b0 || tx_log[k] !== 1'b1) ok = 1'b0;
        total++; if (ok !== 1'b1) $display("FAIL reset_write_ignored got activity=%b want 0", !ok); else passed++;
    endtask

    task automatic test_single();
        int   n;
        logic ok;
        n = cyc + 2;
        push_at(n, 8'h55);
        wait_until(n + 45);
        total++; if (tx_log[n + 1] !== 1'b1) $display("FAIL single_pre_start tx got %b want 1", tx_log[n + 1]); else passed++;
        total++; if (busy_log[n + 1] !== 1'b1) $display("FAIL single_busy_rise got %b want 1", busy_log[n + 1]); else passed++;
        total++; if (got_frame(n + 2) !== exp_frame(8'h55))
            $display("FAIL single_frame got %h want %h", got_frame(n + 2), exp_frame(8'h55)); else passed++;
        ok = 1'b1;
        for (int k = n + 1; k <= n + 41; k++) if (busy_log[k] !== 1'b1) ok = 1'b0;
        total++; if (ok !== 1'b1) $display("FAIL single_busy_hold got drop=%b want 0", !ok); else passed++;
        total++; if (busy_log[n + 42] !== 1'b0) $display("FAIL single_busy_fall got %b want 0", busy_log[n + 42]); else passed++;
        total++; if (tx_log[n + 42] !== 1'b1) $display("FAIL single_idle_tx got %b want 1", tx_log[n + 42]); else passed++;
    endtask

    task automatic test_back_to_back();
        int          n;
        logic        ok;
        logic [7:0]  b [3];
        b = '{8'h41, 8'h42, 8'h43};
        n = cyc + 2;
        for (int i = 0; i < 3; i++) push_at(n + i, b[i]);
        wait_until(n + 130);
        for (int i = 0; i < 3; i++) begin
            total++; if (got_frame(n + 2 + 40 * i) !== exp_frame(b[i]))
                $display("FAIL b2b_frame%0d got %h want %h", i, got_frame(n + 2 + 40 * i), exp_frame(b[i])); else passed++;
        end
        ok = 1'b1;
        for (int k = n + 1; k <= n + 121; k++) if (busy_log[k] !== 1'b1) ok = 1'b0;
        total++; if (ok !== 1'b1) $display("FAIL b2b_busy_hold got drop=%b want 0", !ok); else passed++;
        total++; if (busy_log[n + 122] !== 1'b0) $display("FAIL b2b_busy_fall got %b want 0", busy_log[n + 122]); else passed++;
    endtask

    task automatic test_overflow();
        int          n;
        int          pulses;
        logic        ok;
        logic [7:0]  b [6];
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        n = cyc + 2;
        for (int i = 0; i < 6; i++) push_at(n + i, b[i]);
        wait_until(n + 260);
        total++; if (full_log[n + 4] !== 1'b1) $display("FAIL ovf_full got %b want 1", full_log[n + 4]); else passed++;
        total++; if (ov_log[n + 5] !== 1'b1) $display("FAIL ovf_pulse got %b want 1", ov_log[n + 5]); else passed++;
        pulses = 0;
        for (int k = n; k <= n + 250; k++) if (ov_log[k] === 1'b1) pulses++;
        total++; if (pulses != 1) $display("FAIL ovf_pulse_count got %0d want 1", pulses); else passed++;
        for (int i = 0; i < 5; i++) begin
            total++; if (got_frame(n + 2 + 40 * i) !== exp_frame(b[i]))
                $display("FAIL ovf_frame%0d got %h want %h", i, got_frame(n + 2 + 40 * i), exp_frame(b[i])); else passed++;
        end
        ok = 1'b1;
        for (int k = n + 202; k <= n + 250; k++) if (tx_log[k] !== 1'b1) ok = 1'b0;
        total++; if (ok !== 1'b1) $display("FAIL ovf_no_sixth_frame got extra=%b want 0", !ok); else passed++;
        total++; if (busy_log[n + 203] !== 1'b0) $display("FAIL ovf_busy_fall got %b want 0", busy_log[n + 203]); else passed++;
    endtask

    task automatic test_full_pop();
        int          n;
        int          pulses;
        logic [7:0]  b [6];
        b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'h96};
        n = cyc + 2;
        for (int i = 0; i < 5; i++) push_at(n + i, b[i]);
        push_at(n + 41, b[5]);
        wait_until(n + 250);
        total++; if (full_log[n + 40] !== 1'b1) $display("FAIL fullpop_full_before got %b want 1", full_log[n + 40]); else passed++;
        total++; if (full_log[n + 41] !== 1'b1) $display("FAIL fullpop_full_after got %b want 1", full_log[n + 41]); else passed++;
        pulses = 0;
        for (int k = n; k <= n + 249; k++) if (ov_log[k] === 1'b1) pulses++;
        total++; if (pulses != 0) $display("FAIL fullpop_overflow got %0d pulses want 0", pulses); else passed++;
        for (int i = 0; i < 6; i++) begin
            total++; if (got_frame(n + 2 + 40 * i) !== exp_frame(b[i]))
                $display("FAIL fullpop_frame%0d got %h want %h", i, got_frame(n + 2 + 40 * i), exp_frame(b[i])); else passed++;
        end
        total++; if (busy_log[n + 243] !== 1'b0) $display("FAIL fullpop_busy_fall got %b want 0", busy_log[n + 243]); else passed++;
    endtask

    task automatic test_reset_midframe();
        int   n;
        int   base;
        logic ok;
        n = cyc + 2;
        push_at(n, 8'hA5);
        push_at(n + 1, 8'h01);
        push_at(n + 2, 8'h02);
        wait_until(n + 2 + 17);
        total++; if (bus.tx !== 1'b0) $display("FAIL midrst_bit3 got %b want 0", bus.tx); else passed++;
        rst = 1'b0;
        #1;
        total++; if (bus.tx !== 1'b1) $display("FAIL midrst_tx got %b want 1", bus.tx); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", bus.busy); else passed++;
        total++; if (bus.fifo_full !== 1'b0) $display("FAIL midrst_full got %b want 0", bus.fifo_full); else passed++;
        repeat (3) @(negedge clk);
        rst  = 1'b1;
        base = cyc;
        wait_until(base + 102);
        ok = 1'b1;
        for (int k = base + 1; k <= base + 100; k++)
            if (tx_log[k] !== 1'b1 || busy_log[k] !== 1'b0) ok = 1'b0;
        total++; if (ok !== 1'b1) $display("FAIL midrst_quiet got activity=%b want 0", !ok); else passed++;
    endtask

    task automatic test_extremes();
        int n;
        n = cyc + 2;
        push_at(n, 8'h00);
        push_at(n + 1, 8'hFF);
        wait_until(n + 90);
        total++; if (got_frame(n + 2) !== exp_frame(8'h00))
            $display("FAIL ext_frame00 got %h want %h", got_frame(n + 2), exp_frame(8'h00)); else passed++;
        total++; if (got_frame(n + 42) !== exp_frame(8'hFF))
            $display("FAIL ext_frameFF got %h want %h", got_frame(n + 42), exp_frame(8'hFF)); else passed++;
        total++; if (busy_log[n + 82] !== 1'b0) $display("FAIL ext_busy_fall got %b want 0", busy_log[n + 82]); else passed++;
    endtask

    initial begin
        bus.uart    = 8'h00;
        bus.uart_we = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_midframe();
        test_extremes();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
